// File: rtl/bram_pin_shifter_pkg.sv
// Shared types and sizing helpers for the BRAM pin-shifter stimulus/response engine.
package bram_pin_shifter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        STROBE = 3'd2,
        READ   = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam int DEF_DIN_N  = 8;
    localparam int DEF_DOUT_N = 8;

    // One extra bit above the longest phase so the counter never needs to wrap.
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/bram_pin_shifter.sv
// Serial stimulus/response engine: shifts a stimulus word MSB-first onto dut_di,
// pulses dut_stb, then shifts dut_do back in and offers it as a response word.
module bram_pin_shifter
    import bram_pin_shifter_pkg::*;
#(
    parameter int DIN_N  = DEF_DIN_N,
    parameter int DOUT_N = DEF_DOUT_N
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIN_N-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DOUT_N-1:0] out_data,
    output logic              dut_di,
    output logic              dut_stb,
    input  logic              dut_do,
    output logic              busy
);

    localparam int            CW         = cnt_width(DIN_N, DOUT_N);
    localparam logic [CW-1:0] SHIFT_LOAD = CW'(DIN_N - 1);
    localparam logic [CW-1:0] READ_LOAD  = CW'(DOUT_N - 1);

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic [DIN_N-1:0]  sreg;
    logic [DIN_N-1:0]  sreg_next;
    logic              di_next;
    logic              stb_next;
    logic              cnt_zero;

    assign cnt_zero = (cnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = SHIFT;
            SHIFT:   if (cnt_zero)  state_next = STROBE;
            STROBE:                 state_next = READ;
            READ:    if (cnt_zero)  state_next = RESP;
            RESP:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == RESP);
        busy      = (state != IDLE);

        sreg_next = sreg;
        if (state == IDLE && in_valid) begin
            sreg_next = in_data;
        end else if (state == SHIFT) begin
            // Rotate rather than shift: the low bits only matter until they reach the MSB.
            sreg_next = {sreg[DIN_N-2:0], sreg[DIN_N-1]};
        end

        // dut_di/dut_stb are registered, so they are computed for the upcoming cycle.
        di_next  = (state_next == SHIFT) ? sreg_next[DIN_N-1] : 1'b0;
        stb_next = (state_next == STROBE);
    end

    // Counter reloads on each state entry and otherwise counts down to zero and holds.
    always_comb begin
        cnt_next = cnt;
        if (state_next != state) begin
            case (state_next)
                SHIFT:   cnt_next = SHIFT_LOAD;
                READ:    cnt_next = READ_LOAD;
                default: cnt_next = '0;
            endcase
        end else if (!cnt_zero) begin
            cnt_next = cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            sreg     <= '0;
            dut_di   <= 1'b0;
            dut_stb  <= 1'b0;
            out_data <= '0;
        end else begin
            cnt     <= cnt_next;
            sreg    <= sreg_next;
            dut_di  <= di_next;
            dut_stb <= stb_next;
            // First sample lands in the MSB after DOUT_N shifts; frozen outside READ.
            if (state == READ) begin
                out_data <= {out_data[DOUT_N-2:0], dut_do};
            end
        end
    end

endmodule

// File: tb/tb_bram_pin_shifter.sv
// Directed bench for bram_pin_shifter with a behavioural pin-shifter DUT (dout = din loopback).
module tb_bram_pin_shifter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       dut_di;
    logic       dut_stb;
    logic       dut_do;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int t_accept = 0;
    int t_first  = 0;
    bit noise = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bram_pin_shifter #(.DIN_N(8), .DOUT_N(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .dut_di    (dut_di),
        .dut_stb   (dut_stb),
        .dut_do    (dut_do),
        .busy      (busy)
    );

    // Pin-shifter model: din shift register, strobe-loaded din, dout shift register.
    logic [7:0] m_din      = '0;
    logic [7:0] m_din_shr  = '0;
    logic [7:0] m_dout_shr = '0;

    always @(posedge clk) begin
        m_din_shr <= {m_din_shr[6:0], dut_di};
        if (dut_stb) begin
            m_din      <= m_din_shr;
            m_dout_shr <= m_din;
        end else begin
            m_dout_shr <= {m_dout_shr[6:0], 1'b0};
        end
    end
    assign dut_do = m_dout_shr[7];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (noise) in_data = 8'($urandom);
    endtask

    task automatic run_xact(input logic [7:0] w, input logic [7:0] exp,
                            input int hold, input bit nz);
        check("accept_ready", in_ready, 1);
        in_valid  = 1'b1;
        in_data   = w;
        out_ready = 1'b1;
        t_accept  = cyc;
        noise     = nz;
        step();
        if (!nz) in_valid = 1'b0;
        check("busy", busy, 1);
        check("in_ready_busy", in_ready, 0);
        for (int k = 0; k < 8; k++) begin
            check("di_bit", dut_di, w[7-k]);
            check("stb_low_shift", dut_stb, 0);
            step();
        end
        check("stb_pulse", dut_stb, 1);
        check("stb_di", dut_di, 0);
        step();
        for (int j = 0; j < 8; j++) begin
            check("read_no_valid", out_valid, 0);
            check("read_stb", dut_stb, 0);
            step();
        end
        check("out_valid", out_valid, 1);
        check("out_data", out_data, exp);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = ~w;
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, exp);
            check("hold_in_ready", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        noise     = 1'b0;
        step();
        check("single_resp", out_valid, 0);
        check("ready_after_resp", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            check("idle_ready", in_ready, 1);
            check("idle_valid", out_valid, 0);
            check("idle_stb", dut_stb, 0);
            check("idle_di", dut_di, 0);
            step();
        end

        // Back-to-back: one-transaction lag, 19-cycle accept period.
        run_xact(8'hA5, 8'h00, 0, 1'b0);
        t_first = t_accept;
        run_xact(8'h3C, 8'hA5, 0, 1'b0);
        check("b2b_gap", t_accept - t_first, 19);

        // Consumer stalls for 10 cycles while a new word is offered.
        run_xact(8'h96, 8'h3C, 10, 1'b0);

        // in_valid stays high with churning in_data throughout the transaction.
        run_xact(8'hC3, 8'h96, 0, 1'b1);

        // Abort during SHIFT bit 4; the aborted word never reaches the DUT.
        check("abort_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("abort_di_bit4", dut_di, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_di", dut_di, 0);
        check("abort_stb", dut_stb, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_data", out_data, 8'h00);

        run_xact(8'hFF, 8'hC3, 0, 1'b0);
        run_xact(8'h00, 8'hFF, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
